// File: rtl/pkt_packer_pkg.sv
// Shared types for the byte-to-word packer: FSM states and the output word record.
package pkt_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DROP
    } pkt_state_e;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  nbytes;
    } pkt_word_t;

endpackage

// File: rtl/pkt_word_obuf.sv
// Single-entry valid/ready output register; a new word may replace the draining one in the same cycle.
module pkt_word_obuf
    import pkt_packer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  pkt_word_t word_i,
    input  logic      ready_i,
    output logic      valid_o,
    output pkt_word_t word_o,
    output logic      in_ready_o
);

    logic      valid_q, valid_d;
    pkt_word_t word_q, word_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (load_i) begin
            valid_d = 1'b1;
            word_d  = word_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    // Held low during reset so no byte can be taken while state is being cleared.
    assign in_ready_o = !rst && (!valid_q || ready_i);
    assign valid_o    = valid_q;
    assign word_o     = word_q;

endmodule

// File: rtl/pkt_word_packer.sv
// Packs a framed byte stream into 32-bit little-lane words, enforcing sop/eop framing and a length cap.
module pkt_word_packer
    import pkt_packer_pkg::*;
#(
    parameter int MAX_PLEN = 2048,
    parameter int LEN_W    = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_data_i,
    input  logic             in_sop_i,
    input  logic             in_eop_i,
    output logic [31:0]      bus_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             start_of_packet_o,
    output logic             end_of_packet_o,
    output logic [2:0]       word_bytes_o,
    output logic             pkt_done_o,
    output logic [LEN_W-1:0] pkt_len_o,
    output logic             err_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PLEN);

    pkt_state_e       state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [1:0]       lane_q, lane_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept, take, trunc, load, sop_w, obuf_ready;
    logic [1:0]       wr_idx;
    logic [31:0]      wr_base, data_w;
    logic [LEN_W-1:0] cnt_new;
    pkt_word_t        word_new, word_out;

    assign accept     = in_valid_i && obuf_ready;
    assign in_ready_o = obuf_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        first_d  = first_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        word_new = '0;
        take     = 1'b0;
        trunc    = 1'b0;
        wr_idx   = lane_q;
        wr_base  = acc_q;
        sop_w    = first_q;
        cnt_new  = (cnt_q == MAX_LEN) ? cnt_q : cnt_q + 1'b1;
        data_w   = '0;

        if (accept) begin
            if (in_sop_i) begin
                // A sop always restarts; only an open packet in PACK counts as aborted.
                take    = 1'b1;
                err_d   = (state_q == PACK);
                wr_idx  = 2'd0;
                wr_base = '0;
                sop_w   = 1'b1;
                cnt_new = LEN_W'(1);
            end else begin
                case (state_q)
                    IDLE:    err_d = 1'b1;
                    PACK:    take  = 1'b1;
                    DROP:    if (in_eop_i) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end

        if (take) begin
            data_w = wr_base;
            data_w[{wr_idx, 3'b000} +: 8] = in_data_i;
            trunc  = !in_eop_i && (cnt_new == MAX_LEN);
            cnt_d  = cnt_new;

            if (in_eop_i || trunc || wr_idx == 2'(WORD_BYTES - 1)) begin
                load     = 1'b1;
                word_new = '{data: data_w, sop: sop_w, eop: in_eop_i || trunc,
                             nbytes: {1'b0, wr_idx} + 3'd1};
                acc_d    = '0;
                lane_d   = 2'd0;
                first_d  = 1'b0;
            end else begin
                acc_d   = data_w;
                lane_d  = wr_idx + 2'd1;
                first_d = sop_w;
            end

            if (in_eop_i) begin
                len_d   = cnt_new;
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (trunc) begin
                len_d   = cnt_new;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = DROP;
            end else begin
                state_d = PACK;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            first_q <= first_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    pkt_word_obuf u_obuf (
        .clk       (CLK),
        .rst       (reset),
        .load_i    (load),
        .word_i    (word_new),
        .ready_i   (word_ready_i),
        .valid_o   (word_valid_o),
        .word_o    (word_out),
        .in_ready_o(obuf_ready)
    );

    assign bus_o             = word_out.data;
    assign start_of_packet_o = word_out.sop;
    assign end_of_packet_o   = word_out.eop;
    assign word_bytes_o      = word_out.nbytes;
    assign pkt_done_o        = done_q;
    assign pkt_len_o         = len_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_pkt_word_packer.sv
// Scoreboard bench: unit 0 uses the default length cap, unit 1 a cap of 8 bytes.
module tb_pkt_word_packer;

    logic        CLK   = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid [2];
    logic        in_sop [2];
    logic        in_eop [2];
    logic        word_ready [2];
    logic [7:0]  in_data [2];
    logic        in_ready [2];
    logic        word_valid [2];
    logic        sop_w [2];
    logic        eop_w [2];
    logic        done_w [2];
    logic        err_w [2];
    logic [31:0] bus_w [2];
    logic [2:0]  nb_w [2];
    logic [15:0] len_w [2];

    always #5 CLK = ~CLK;

    pkt_word_packer dut0 (
        .CLK(CLK), .reset(reset),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .in_sop_i(in_sop[0]), .in_eop_i(in_eop[0]),
        .bus_o(bus_w[0]), .word_valid_o(word_valid[0]), .word_ready_i(word_ready[0]),
        .start_of_packet_o(sop_w[0]), .end_of_packet_o(eop_w[0]), .word_bytes_o(nb_w[0]),
        .pkt_done_o(done_w[0]), .pkt_len_o(len_w[0]), .err_o(err_w[0])
    );

    pkt_word_packer #(.MAX_PLEN(8), .LEN_W(16)) dut1 (
        .CLK(CLK), .reset(reset),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .in_sop_i(in_sop[1]), .in_eop_i(in_eop[1]),
        .bus_o(bus_w[1]), .word_valid_o(word_valid[1]), .word_ready_i(word_ready[1]),
        .start_of_packet_o(sop_w[1]), .end_of_packet_o(eop_w[1]), .word_bytes_o(nb_w[1]),
        .pkt_done_o(done_w[1]), .pkt_len_o(len_w[1]), .err_o(err_w[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Reference model: packets are tracked as a growing byte count and a partial word.
    typedef struct {
        int          unit;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  nb;
        logic        done;
        logic        err;
        int          len;
    } exp_t;

    exp_t        exp_q [$];
    int          maxlen [2] = '{2048, 8};
    bit          in_pkt [2];
    bit          dropping [2];
    logic [31:0] cur_data [2];
    int          cur_n [2];
    int          plen [2];
    int          nwords [2];
    int          exp_err [2];
    int          err_seen [2];

    task automatic model_reset(input int u);
        in_pkt[u]   = 0;
        dropping[u] = 0;
        cur_data[u] = '0;
        cur_n[u]    = 0;
    endtask

    task automatic model_byte(input int u, input logic [7:0] d, input logic s, input logic e);
        bit   abort;
        bit   tr;
        exp_t x;
        abort = 0;
        if (s) begin
            abort = in_pkt[u];
            if (abort) exp_err[u]++;
            in_pkt[u]   = 1;
            dropping[u] = 0;
            cur_data[u] = '0;
            cur_n[u]    = 0;
            plen[u]     = 0;
            nwords[u]   = 0;
        end else if (!in_pkt[u]) begin
            if (dropping[u]) begin
                if (e) dropping[u] = 0;
            end else begin
                exp_err[u]++;
            end
            return;
        end
        cur_data[u] = cur_data[u] | (32'(d) << (8 * cur_n[u]));
        cur_n[u]++;
        plen[u]++;
        tr = !e && (plen[u] == maxlen[u]);
        if (e || tr || cur_n[u] == 4) begin
            x.unit = u;
            x.data = cur_data[u];
            x.sop  = (nwords[u] == 0);
            x.eop  = e || tr;
            x.nb   = 3'(cur_n[u]);
            x.done = e || tr;
            x.err  = abort || tr;
            x.len  = plen[u];
            exp_q.push_back(x);
            if (tr) exp_err[u]++;
            nwords[u]++;
            cur_data[u] = '0;
            cur_n[u]    = 0;
            if (e || tr) begin
                in_pkt[u]   = 0;
                dropping[u] = tr;
            end
        end
    endtask

    // Backpressure: 0 always ready, 1 random, 2 stalled.
    int bp_mode [2] = '{0, 0};
    always @(posedge CLK) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            case (bp_mode[u])
                1:       word_ready[u] = ($urandom_range(0, 3) != 0);
                2:       word_ready[u] = 1'b0;
                default: word_ready[u] = 1'b1;
            endcase
        end
    end

    logic        pv [2];
    logic        pr [2];
    logic [31:0] pbus [2];
    logic [4:0]  pctl [2];
    int          words_seen [2];
    logic [31:0] last_bus [2];
    logic [31:0] first_bus [2];
    logic [4:0]  last_ctl [2];
    bit          saw_stall [2];
    logic        nw;
    exp_t        me;

    always @(negedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                pv[u] = 1'b0;
                pr[u] = 1'b1;
            end else begin
                if (err_w[u]) err_seen[u]++;
                if (word_valid[u] && pv[u] && !pr[u]) begin
                    chk($sformatf("hold_bus_u%0d", u), bus_w[u], pbus[u]);
                    chk($sformatf("hold_ctl_u%0d", u), {sop_w[u], eop_w[u], nb_w[u]}, pctl[u]);
                end
                if (word_valid[u] && !word_ready[u]) begin
                    chk($sformatf("stall_in_ready_u%0d", u), in_ready[u], 0);
                    saw_stall[u] = 1;
                end
                nw = word_valid[u] && !(pv[u] && !pr[u]);
                if (done_w[u]) chk($sformatf("done_on_new_word_u%0d", u), nw, 1);
                if (nw) begin
                    words_seen[u]++;
                    last_bus[u] = bus_w[u];
                    last_ctl[u] = {sop_w[u], eop_w[u], nb_w[u]};
                    if (sop_w[u]) first_bus[u] = bus_w[u];
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word_u%0d: got 0x%0h expected no word", u, bus_w[u]);
                    end else begin
                        me = exp_q.pop_front();
                        chk($sformatf("unit_u%0d", u), u, me.unit);
                        chk($sformatf("data_u%0d", u), bus_w[u], me.data);
                        chk($sformatf("ctl_u%0d", u), {sop_w[u], eop_w[u], nb_w[u]}, {me.sop, me.eop, me.nb});
                        chk($sformatf("pulse_u%0d", u), {done_w[u], err_w[u]}, {me.done, me.err});
                        if (me.done) chk($sformatf("pkt_len_u%0d", u), len_w[u], me.len);
                    end
                end
                pv[u]   = word_valid[u];
                pr[u]   = word_ready[u];
                pbus[u] = bus_w[u];
                pctl[u] = {sop_w[u], eop_w[u], nb_w[u]};
            end
        end
    end

    task automatic send_byte(input int u, input logic [7:0] d, input logic s, input logic e);
        int n;
        n = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_sop[u]   = s;
        in_eop[u]   = e;
        @(negedge CLK);
        while (!in_ready[u] && n < 1000) begin
            n++;
            @(negedge CLK);
        end
        if (!in_ready[u]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_u%0d: got in_ready=0 expected 1 within 1000 cycles", u);
            in_valid[u] = 1'b0;
            return;
        end
        model_byte(u, d, s, e);
        @(posedge CLK);
        #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic send_pkt(input int u, input logic [7:0] base, input int len, input bit with_eop);
        for (int i = 0; i < len; i++)
            send_byte(u, base + 8'(i), i == 0, with_eop && (i == len - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(4);
        for (int u = 0; u < 2; u++) chk($sformatf("err_count_u%0d", u), err_seen[u], exp_err[u]);
    endtask

    task automatic chk_zero(input string name);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_bus_u%0d", name, u), bus_w[u], 0);
            chk($sformatf("%s_ctl_u%0d", name, u),
                {len_w[u], word_valid[u], sop_w[u], eop_w[u], nb_w[u], done_w[u], err_w[u], in_ready[u]}, 0);
        end
    endtask

    int w0, e0, ln, kind, uu;
    bit ab;

    initial begin
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 0; in_sop[u] = 0; in_eop[u] = 0; in_data[u] = 0; word_ready[u] = 1;
            pv[u] = 0; pr[u] = 1; words_seen[u] = 0; saw_stall[u] = 0;
            exp_err[u] = 0; err_seen[u] = 0; plen[u] = 0; nwords[u] = 0;
            model_reset(u);
        end
        #1 reset = 1'b1;
        #2 chk_zero("reset_init");
        @(posedge CLK);
        @(posedge CLK);
        #3 reset = 1'b0;
        idle(1);

        // 46-byte packet with the output always ready
        w0 = words_seen[0];
        send_pkt(0, 8'h00, 46, 1);
        drain();
        chk("p46_words", words_seen[0] - w0, 12);
        chk("p46_first", first_bus[0], 32'h03020100);
        chk("p46_last", last_bus[0], 32'h00002D2C);
        chk("p46_last_ctl", last_ctl[0], 5'b01010);
        chk("p46_len", len_w[0], 46);

        // single-byte packet
        send_byte(0, 8'hA5, 1, 1);
        drain();
        chk("single_bus", last_bus[0], 32'h000000A5);
        chk("single_ctl", last_ctl[0], 5'b11001);

        // 20-byte packet with a 10-cycle downstream stall
        w0 = words_seen[0];
        saw_stall[0] = 0;
        fork
            send_pkt(0, 8'h40, 20, 1);
            begin
                repeat (6) @(posedge CLK);
                bp_mode[0] = 2;
                repeat (10) @(posedge CLK);
                bp_mode[0] = 0;
            end
        join
        drain();
        chk("stall_seen", saw_stall[0], 1);
        chk("stall_words", words_seen[0] - w0, 5);
        chk("stall_last", last_bus[0], 32'h53525150);

        // sop after 6 bytes of packet A
        w0 = words_seen[0];
        e0 = err_seen[0];
        send_pkt(0, 8'h10, 6, 0);
        send_pkt(0, 8'h20, 4, 1);
        drain();
        chk("abort_err", err_seen[0] - e0, 1);
        chk("abort_words", words_seen[0] - w0, 2);
        chk("abort_new_first", first_bus[0], 32'h23222120);
        chk("abort_new_ctl", last_ctl[0], 5'b11100);

        // 11-byte packet against an 8-byte cap, then a normal packet
        w0 = words_seen[1];
        e0 = err_seen[1];
        send_pkt(1, 8'h30, 11, 1);
        drain();
        chk("cap_words", words_seen[1] - w0, 2);
        chk("cap_len", len_w[1], 8);
        chk("cap_err", err_seen[1] - e0, 1);
        chk("cap_last", last_bus[1], 32'h37363534);
        send_pkt(1, 8'h60, 3, 1);
        drain();
        chk("cap_next_ctl", last_ctl[1], 5'b11011);
        chk("cap_next_len", len_w[1], 3);

        // reset in the middle of a packet
        send_byte(0, 8'h77, 1, 0);
        send_byte(0, 8'h78, 0, 0);
        idle(2);
        e0 = err_seen[0];
        #2 reset = 1'b1;
        #1 chk_zero("reset_mid");
        @(posedge CLK);
        #3 reset = 1'b0;
        model_reset(0);
        model_reset(1);
        idle(1);
        w0 = words_seen[0];
        send_pkt(0, 8'h81, 4, 1);
        drain();
        chk("post_reset_words", words_seen[0] - w0, 1);
        chk("post_reset_ctl", last_ctl[0], 5'b11100);
        chk("post_reset_bus", last_bus[0], 32'h84838281);
        chk("post_reset_no_err", err_seen[0] - e0, 0);

        // randomized traffic with random backpressure, aborts and stray bytes
        bp_mode[0] = 1;
        bp_mode[1] = 1;
        for (int p = 0; p < 60; p++) begin
            uu   = (p % 3 == 2) ? 1 : 0;
            ln   = $urandom_range(1, (uu == 1) ? 14 : 70);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                send_byte(uu, 8'($urandom), 0, 1'($urandom_range(0, 1)));
            end else begin
                ab = (kind == 1);
                for (int i = 0; i < ln; i++) begin
                    send_byte(uu, 8'($urandom), i == 0, !ab && (i == ln - 1));
                    if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
                end
            end
        end
        bp_mode[0] = 0;
        bp_mode[1] = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_word_packer.md
# pkt_word_packer

- Upstream feeder for `PacketParserN6`.
- Accepts a byte-serial packet stream with valid/ready, sop and eop.
- Packs the bytes into the 32-bit little-lane words the parser consumes on `bus`, and marks start, end and valid byte count of each word.
- Enforces packet framing and a maximum length, so the parser only sees well-formed word streams.

## Interface

**Parameters**
- `MAX_PLEN`, default 2048: maximum packet length in bytes; bytes beyond it are dropped.
- `LEN_W`, default 16: width of the byte-length counter; must satisfy `MAX_PLEN < 2**LEN_W`.

**Ports** (one clock; `reset` is asynchronous and active-high)
- `CLK`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid_i`  in  1  input byte valid
- `in_ready_o`  out  1  byte accepted when both `in_valid_i` and `in_ready_o` are high at the rising edge of `CLK`
- `in_data_i`  in  8  byte
- `in_sop_i`  in  1  first byte of packet
- `in_eop_i`  in  1  last byte of packet
- `bus_o`  out  32  packed word; byte k of the word is in `[8k+7:8k]`
- `word_valid_o`  out  1  word present
- `word_ready_i`  in  1  downstream accepts the word
- `start_of_packet_o`  out  1  word holds packet byte 0
- `end_of_packet_o`  out  1  last word of packet
- `word_bytes_o`  out  3  valid bytes in the word, 1..4
- `pkt_done_o`  out  1  one-cycle pulse when an eop word is loaded
- `pkt_len_o`  out  LEN_W  byte length of the last completed packet
- `err_o`  out  1  one-cycle pulse on a framing or length error

## Operation

**States:** IDLE, PACK, DROP.

**Accumulator:** 4-byte register, lane pointer `lane` (0..3), byte counter `cnt`.

**IDLE**
- A byte with sop is written to lane 0; `cnt` = 1.
- If that byte also has eop, the word is emitted immediately with `word_bytes` = 1 and sop = eop = 1. Otherwise the FSM goes to PACK.
- A byte without sop is dropped and `err_o` pulses.

**PACK**
- Each accepted byte is written to `acc[lane]`; `lane` increments and `cnt` increments.
- A word is emitted when `lane` == 3 or the byte has eop:
  - `word_bytes` = `lane` + 1.
  - Unused lanes are 0.
  - sop is set only on the packet's first word.
- On eop: `pkt_len_o` ← `cnt` (including this byte), `pkt_done_o` pulses, and the FSM returns to IDLE.
- sop arriving in PACK:
  - Partial accumulator contents are discarded and `err_o` pulses.
  - The byte starts a new packet (lane 0, `cnt` = 1).
  - No eop word is emitted for the aborted packet.
- Byte number `MAX_PLEN` without eop:
  - The word is emitted with `end_of_packet_o` = 1.
  - `pkt_len_o` = `MAX_PLEN`, `pkt_done_o` and `err_o` pulse, and the FSM goes to DROP.

**DROP**
- Bytes are accepted and discarded until an eop byte, then the FSM returns to IDLE.
- A sop byte in DROP starts a new packet as in IDLE.

**Backpressure**
- The output holds one word.
- `in_ready_o` = !`word_valid_o` || `word_ready_i`. It applies in every state, so input byte order is never broken.
- Output fields are stable while `word_valid_o` && !`word_ready_i`.

**Reset**
- Asynchronous clear: state IDLE, `lane` = 0, `cnt` = 0, accumulator 0.
- All outputs are 0, except `in_ready_o` = 1 once reset is deasserted.
- A packet interrupted by reset is lost with no error pulse.

## Timing

- **Latency:** a word appears on `word_valid_o` in the cycle after the edge that accepts its completing byte.
- **Throughput:** 1 byte/cycle with `word_ready_i` held high; one word every 4 cycles for full words.
- **Simultaneous events:** output drain and load in the same cycle are legal; the new word replaces the old one with no bubble.
- **Pulse alignment:** `pkt_done_o` and `err_o` are registered. They are asserted in the same cycle the associated word, or drop decision, becomes visible.
- **Counter width:** `cnt` saturates at `MAX_PLEN`; it never wraps.

## Structure

- `pkt_packer_pkg` holds:
  - the state enum {IDLE, PACK, DROP};
  - `WORD_BYTES` = 4;
  - a struct `pkt_word_t` {data[31:0], sop, eop, nbytes[2:0]}.
- Sub-module `pkt_word_obuf`: single-entry valid/ready register carrying `pkt_word_t`. It produces the `in_ready_o` term.
- The top level contains the FSM, accumulator and counters.

## Test plan

- 46-byte packet 0x00..0x2D, `word_ready_i` = 1:
  - 12 words; first word 0x03020100 with sop.
  - Last word 0x00002D2C, `word_bytes` = 2, eop.
  - `pkt_len_o` = 46.
- Single byte 0xA5 with sop and eop → one word 0x000000A5, `word_bytes` = 1, sop = eop = 1, `pkt_done_o`.
- `word_ready_i` low for 10 cycles during a 20-byte packet:
  - `in_ready_o` drops.
  - Word held stable.
  - No byte lost; sequence identical to the unstalled run.
- sop after 6 bytes of packet A:
  - `err_o` pulses.
  - Bytes 4–5 of A are never emitted.
  - The new packet's first word carries sop.
- `MAX_PLEN` = 8, 11-byte packet:
  - Two words, the second with eop.
  - `pkt_len_o` = 8 and `err_o` pulse.
  - Bytes 9–11 dropped; the next sop packet is normal.
- `reset` asserted mid-packet:
  - All outputs are 0 asynchronously.
  - A subsequent 4-byte packet yields one word with sop, eop and `word_bytes` = 4.
